fwd_hazard_scoreboard: RTL and testbench

//  Parametrised forwarding and hazard unit for the 16-bit pipeline. It keeps its own

---
 rtl/fwd_hazard_scoreboard.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard scoreboard for the 16-bit pipeline.
// A shift-register table follows every in-flight writer from EX down to R_DEPTH.
// For each decode-stage source operand the block does two things. It computes a
// forward select that EX uses one cycle later. It stalls decode when the
// youngest matching producer will not have its result ready in time.
module fwd_hazard_scoreboard #(
   parameter int AW       = 4,
   parameter int NUM_SRC  = 2,
   parameter int DEPTH    = 3,
   parameter int ZERO_REG = 0,
   parameter int CNT_W    = 16,
   localparam int SW      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic                  id_regwrite,
   input  logic [AW-1:0]         id_rd,
   input  logic [SW-1:0]         id_lat,
   input  logic [NUM_SRC*AW-1:0] id_src,
   input  logic [NUM_SRC-1:0]    id_src_used,
   input  logic                  hold,
   output logic                  stall,
   output logic [NUM_SRC*SW-1:0] ex_fwd_sel,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [AW-1:0] ZERO_RD  = AW'(ZERO_REG);
   localparam logic [SW-1:0] DEPTH_SW = SW'(DEPTH);

   logic [DEPTH-1:0]          t_valid_q, t_valid_d;
   logic [DEPTH-1:0][AW-1:0]  t_rd_q,    t_rd_d;
   logic [DEPTH-1:0][SW-1:0]  t_lat_q,   t_lat_d;
   logic [NUM_SRC*SW-1:0]     fwd_sel_q, fwd_sel_d;
   logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

   logic [NUM_SRC-1:0]        src_hazard;
   logic [NUM_SRC*SW-1:0]     id_sel;
   logic [SW-1:0]             lat_clamped;
   logic                      alloc;

   // Per source: find the youngest matching writer, then decide between forwarding and stalling
   always_comb begin
      src_hazard = '0;
      id_sel     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         logic [AW-1:0] src;
         logic          found;
         src   = id_src[i*AW +: AW];
         found = 1'b0;
         if (id_valid && id_src_used[i] && (src != ZERO_RD)) begin
            for (int j = 0; j < DEPTH; j++) begin
               if (!found && t_valid_q[j] && (t_rd_q[j] == src)) begin
                  found = 1'b1;
                  if (t_lat_q[j] <= SW'(j + 1)) begin
                     id_sel[i*SW +: SW] = SW'(j + 1);
                  end else begin
                     src_hazard[i] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Clamp the incoming latency into 1..DEPTH and decide whether ID allocates an entry
   always_comb begin
      lat_clamped = id_lat;
      if (id_lat == '0) begin
         lat_clamped = SW'(1);
      end else if (id_lat > DEPTH_SW) begin
         lat_clamped = DEPTH_SW;
      end
      alloc = id_valid && id_regwrite && (id_rd != ZERO_RD);
      stall = (|src_hazard) && !hold;
   end

   // Next state: freeze on hold, otherwise advance the table and insert either a bubble or the ID writer
   always_comb begin
      t_valid_d   = t_valid_q;
      t_rd_d      = t_rd_q;
      t_lat_d     = t_lat_q;
      fwd_sel_d   = fwd_sel_q;
      stall_cnt_d = stall_cnt_q;
      if (!hold) begin
         for (int j = 1; j < DEPTH; j++) begin
            t_valid_d[j] = t_valid_q[j-1];
            t_rd_d[j]    = t_rd_q[j-1];
            t_lat_d[j]   = t_lat_q[j-1];
         end
         if (stall) begin
            t_valid_d[0] = 1'b0;
            fwd_sel_d    = '0;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
         end else begin
            t_valid_d[0] = alloc;
            t_rd_d[0]    = id_rd;
            t_lat_d[0]   = lat_clamped;
            fwd_sel_d    = id_sel;
         end
      end
   end

   // State registers; reset drops every in-flight writer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_valid_q   <= '0;
         t_rd_q      <= '0;
         t_lat_q     <= '0;
         fwd_sel_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         t_valid_q   <= t_valid_d;
         t_rd_q      <= t_rd_d;
         t_lat_q     <= t_lat_d;
         fwd_sel_q   <= fwd_sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_fwd_sel = fwd_sel_q;
   assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard covering forwarding distance, load-use stalls,
// youngest-match priority, the zero register, hold, latency clamp and mid-stream reset.
module tb_fwd_hazard_scoreboard;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic       id_regwrite;
   logic [3:0] id_rd;
   logic [1:0] id_lat;
   logic [7:0] id_src;
   logic [1:0] id_src_used;
   logic       hold;
   logic       stall;
   logic [3:0] ex_fwd_sel;
   logic [15:0] stall_cnt;

   int checkCount = 0;
   int errorCount = 0;

   fwd_hazard_scoreboard dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_valid    (id_valid),
      .id_regwrite (id_regwrite),
      .id_rd       (id_rd),
      .id_lat      (id_lat),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .hold        (hold),
      .stall       (stall),
      .ex_fwd_sel  (ex_fwd_sel),
      .stall_cnt   (stall_cnt)
   );

   // Free-running clock, active edge is posedge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one ID-stage instruction plus hold, then let the combinational stall settle
   task automatic applyStimulus(input logic v, input logic rw, input logic [3:0] rd,
                                input logic [1:0] lat, input logic [3:0] s1,
                                input logic [3:0] s0, input logic [1:0] used,
                                input logic hld);
      id_valid    = v;
      id_regwrite = rw;
      id_rd       = rd;
      id_lat      = lat;
      id_src      = {s1, s0};
      id_src_used = used;
      hold        = hld;
      #1;
   endtask

   task automatic nop();
      applyStimulus(1'b0, 1'b0, 4'd0, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
   endtask

   // Advance one clock and sample just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      nop();
      tick();
      tick();
      tick();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      nop();
      #1;
      checkOutput("reset sel", 32'(ex_fwd_sel), 32'h0);
      checkOutput("reset cnt", 32'(stall_cnt), 32'h0);
      checkOutput("reset stall", 32'(stall), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;

      $display("[TB] ALU forward by distance");
      applyStimulus(1'b1, 1'b1, 4'd3, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd3, 2'b01, 1'b0);
      checkOutput("alu stall", 32'(stall), 32'h0);
      tick();
      checkOutput("alu sel1", 32'(ex_fwd_sel), 32'h1);
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd3, 4'd0, 2'b10, 1'b0);
      tick();
      checkOutput("alu sel2", 32'(ex_fwd_sel), 32'h8);
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd3, 2'b01, 1'b0);
      tick();
      checkOutput("alu sel3", 32'(ex_fwd_sel), 32'h3);
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd3, 2'b01, 1'b0);
      tick();
      checkOutput("retired sel", 32'(ex_fwd_sel), 32'h0);

      $display("[TB] load-use");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd5, 2'd2, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd5, 4'd0, 2'b10, 1'b0);
      checkOutput("lu stall", 32'(stall), 32'h1);
      tick();
      checkOutput("lu bubble sel", 32'(ex_fwd_sel), 32'h0);
      checkOutput("lu cnt", 32'(stall_cnt), 32'h1);
      checkOutput("lu stall released", 32'(stall), 32'h0);
      tick();
      checkOutput("lu sel2", 32'(ex_fwd_sel), 32'h8);
      checkOutput("lu cnt hold", 32'(stall_cnt), 32'h1);

      $display("[TB] youngest match wins");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd4, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 4'd4, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd4, 2'b01, 1'b0);
      checkOutput("young stall", 32'(stall), 32'h0);
      tick();
      checkOutput("young sel", 32'(ex_fwd_sel), 32'h1);

      $display("[TB] zero register and unused sources");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd0, 2'd2, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd0, 2'b11, 1'b0);
      checkOutput("r0 stall", 32'(stall), 32'h0);
      tick();
      checkOutput("r0 sel", 32'(ex_fwd_sel), 32'h0);
      applyStimulus(1'b1, 1'b1, 4'd6, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd6, 4'd6, 2'b00, 1'b0);
      checkOutput("unused stall", 32'(stall), 32'h0);
      tick();
      checkOutput("unused sel", 32'(ex_fwd_sel), 32'h0);
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd6, 4'd6, 2'b11, 1'b0);
      tick();
      checkOutput("same reg both", 32'(ex_fwd_sel), 32'hA);

      $display("[TB] load-use under hold");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd7, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 4'd5, 2'd2, 4'd0, 4'd7, 2'b01, 1'b0);
      tick();
      checkOutput("pre-hold sel", 32'(ex_fwd_sel), 32'h1);
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd5, 4'd0, 2'b10, 1'b1);
      checkOutput("hold stall masked", 32'(stall), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("hold sel frozen", 32'(ex_fwd_sel), 32'h1);
         checkOutput("hold cnt frozen", 32'(stall_cnt), 32'h1);
         checkOutput("hold stall", 32'(stall), 32'h0);
      end
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd5, 4'd0, 2'b10, 1'b0);
      checkOutput("post-hold stall", 32'(stall), 32'h1);
      tick();
      checkOutput("post-hold bubble", 32'(ex_fwd_sel), 32'h0);
      checkOutput("post-hold cnt", 32'(stall_cnt), 32'h2);
      checkOutput("post-hold released", 32'(stall), 32'h0);
      tick();
      checkOutput("post-hold sel2", 32'(ex_fwd_sel), 32'h8);

      $display("[TB] latency clamp and longest latency");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd10, 2'd0, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd10, 2'b01, 1'b0);
      checkOutput("lat0 stall", 32'(stall), 32'h0);
      tick();
      checkOutput("lat0 sel", 32'(ex_fwd_sel), 32'h1);
      flush();
      applyStimulus(1'b1, 1'b1, 4'd11, 2'd3, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd11, 2'b01, 1'b0);
      checkOutput("lat3 stall a", 32'(stall), 32'h1);
      tick();
      checkOutput("lat3 stall b", 32'(stall), 32'h1);
      tick();
      checkOutput("lat3 stall c", 32'(stall), 32'h0);
      checkOutput("lat3 cnt", 32'(stall_cnt), 32'h4);
      tick();
      checkOutput("lat3 sel", 32'(ex_fwd_sel), 32'h3);

      $display("[TB] asynchronous reset mid-stream");
      flush();
      applyStimulus(1'b1, 1'b1, 4'd9, 2'd1, 4'd0, 4'd0, 2'b00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd0, 4'd9, 2'b01, 1'b0);
      tick();
      checkOutput("pre-reset sel", 32'(ex_fwd_sel), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async reset sel", 32'(ex_fwd_sel), 32'h0);
      checkOutput("async reset cnt", 32'(stall_cnt), 32'h0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 4'd0, 2'd1, 4'd9, 4'd9, 2'b11, 1'b0);
      checkOutput("after reset stall", 32'(stall), 32'h0);
      tick();
      checkOutput("after reset sel", 32'(ex_fwd_sel), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
